// File: rtl/pc_redirect_ctrl_if.sv
// Redirect controller bus: redirect requests from the branch manager and the
// ID stage, the redirect handshake toward fetch, and pipeline squash controls.
interface pc_redirect_ctrl_if #(
  parameter int WordSize = 32
);
  logic                mispredict_valid;
  logic [WordSize-1:0] mispredict_npc;
  logic                jump_valid;
  logic [WordSize-1:0] jump_npc;
  logic                fetch_ready;
  logic                redirect_valid;
  logic [WordSize-1:0] redirect_pc;
  logic                flush_if;
  logic                flush_id;
  logic                stall_fetch;
  logic                busy;
  logic [7:0]          redirect_count;

  // Pipeline side: raises requests, consumes the redirect and squash controls
  modport master (
    output mispredict_valid, mispredict_npc, jump_valid, jump_npc, fetch_ready,
    input  redirect_valid, redirect_pc, flush_if, flush_id, stall_fetch, busy,
           redirect_count
  );

  // Controller side
  modport slave (
    input  mispredict_valid, mispredict_npc, jump_valid, jump_npc, fetch_ready,
    output redirect_valid, redirect_pc, flush_if, flush_id, stall_fetch, busy,
           redirect_count
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: latches a mispredict or jump target, squashes the
// front-end pipeline registers for FlushCycles cycles, then offers the
// word-aligned target to fetch until it is accepted. A late mispredict always
// overrides whatever redirect is in progress.
module pc_redirect_ctrl #(
  parameter int WordSize    = 32,
  parameter int FlushCycles = 2
) (
  input logic              clk,
  input logic              rstn_h,
  pc_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FLUSH, ISSUE} state_t;

  localparam logic [3:0]          FlushLoad = 4'(FlushCycles);
  localparam logic [WordSize-1:0] AlignMask = ~(WordSize'(3));

  state_t              state_q, state_d;
  logic [WordSize-1:0] target_q, target_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          count_q, count_d;
  logic                restart_q;

  logic                redirect_valid_c;
  logic [WordSize-1:0] redirect_pc_c;
  logic                flush_c;
  logic                stall_c;

  // Restart flag: blocks request sampling on the first edge after reset
  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) restart_q <= 1'b1;
    else         restart_q <= 1'b0;
  end

  // State, latched target, squash down-counter and saturating redirect count
  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      state_q  <= IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic and Moore outputs; a mispredict outranks jumps and handshakes
  always_comb begin
    state_d          = state_q;
    target_d         = target_q;
    cnt_d            = cnt_q;
    count_d          = count_q;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = '0;
    flush_c          = 1'b0;
    stall_c          = 1'b0;

    case (state_q)
      IDLE: begin
        if (!restart_q && bus.mispredict_valid) begin
          target_d = bus.mispredict_npc & AlignMask;
          cnt_d    = FlushLoad;
          state_d  = FLUSH;
        end else if (!restart_q && bus.jump_valid) begin
          target_d = bus.jump_npc & AlignMask;
          cnt_d    = FlushLoad;
          state_d  = FLUSH;
        end
      end

      FLUSH: begin
        flush_c = 1'b1;
        stall_c = 1'b1;
        if (bus.mispredict_valid) begin
          target_d = bus.mispredict_npc & AlignMask;
          cnt_d    = FlushLoad;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ISSUE: begin
        redirect_valid_c = 1'b1;
        redirect_pc_c    = target_q;
        stall_c          = 1'b1;
        if (bus.mispredict_valid) begin
          target_d = bus.mispredict_npc & AlignMask;
          cnt_d    = FlushLoad;
          state_d  = FLUSH;
        end else if (bus.fetch_ready) begin
          state_d = IDLE;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.redirect_valid = redirect_valid_c;
  assign bus.redirect_pc    = redirect_pc_c;
  assign bus.flush_if       = flush_c;
  assign bus.flush_id       = flush_c;
  assign bus.stall_fetch    = stall_c;
  assign bus.busy           = (state_q != IDLE);
  assign bus.redirect_count = count_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with FlushCycles=2; every expected value
// below is worked out by hand from the redirect timing.
module tb_pc_redirect_ctrl;

  logic clk;
  logic rstn_h;
  int   checks;
  int   errors;
  int   exp_count;

  pc_redirect_ctrl_if #(.WordSize(32)) bus ();

  pc_redirect_ctrl #(.WordSize(32), .FlushCycles(2)) dut (
    .clk    (clk),
    .rstn_h (rstn_h),
    .bus    (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic mv, input logic [31:0] mnpc,
                               input logic jv, input logic [31:0] jnpc,
                               input logic fr);
    bus.mispredict_valid = mv;
    bus.mispredict_npc   = mnpc;
    bus.jump_valid       = jv;
    bus.jump_npc         = jnpc;
    bus.fetch_ready      = fr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Advance one cycle and land just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_count = 0;
    rstn_h    = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rst_busy",  32'(bus.busy), 32'd0);
    checkOutput("rst_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("rst_pc",    bus.redirect_pc, 32'h0);
    checkOutput("rst_flush", 32'(bus.flush_if), 32'd0);
    checkOutput("rst_stall", 32'(bus.stall_fetch), 32'd0);
    checkOutput("rst_count", 32'(bus.redirect_count), 32'd0);
    tick();
    tick();
    rstn_h = 1'b1;
    tick();

    // Jump to 0x1003 with fetch ready throughout: aligned to 0x1000
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_1003, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("jmp_flush_if1", 32'(bus.flush_if), 32'd1);
    checkOutput("jmp_flush_id1", 32'(bus.flush_id), 32'd1);
    checkOutput("jmp_stall1",    32'(bus.stall_fetch), 32'd1);
    checkOutput("jmp_busy1",     32'(bus.busy), 32'd1);
    checkOutput("jmp_valid1",    32'(bus.redirect_valid), 32'd0);
    tick();
    checkOutput("jmp_flush_if2", 32'(bus.flush_if), 32'd1);
    checkOutput("jmp_valid2",    32'(bus.redirect_valid), 32'd0);
    tick();
    checkOutput("jmp_issue_valid", 32'(bus.redirect_valid), 32'd1);
    checkOutput("jmp_issue_pc",    bus.redirect_pc, 32'h0000_1000);
    checkOutput("jmp_issue_flush", 32'(bus.flush_if), 32'd0);
    checkOutput("jmp_issue_stall", 32'(bus.stall_fetch), 32'd1);
    tick();
    checkOutput("jmp_done_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("jmp_done_busy",  32'(bus.busy), 32'd0);
    checkOutput("jmp_done_pc",    bus.redirect_pc, 32'h0);
    checkOutput("jmp_done_count", 32'(bus.redirect_count), 32'd1);

    // Mispredict and jump together: mispredict wins, jump discarded
    applyStimulus(1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    tick();
    checkOutput("prio_valid", 32'(bus.redirect_valid), 32'd1);
    checkOutput("prio_pc",    bus.redirect_pc, 32'h200);
    tick();
    checkOutput("prio_count", 32'(bus.redirect_count), 32'd2);
    tick();
    checkOutput("prio_no_jump_busy",  32'(bus.busy), 32'd0);
    checkOutput("prio_no_jump_valid", 32'(bus.redirect_valid), 32'd0);

    // Mispredict to 0x100, fetch stalls for 5 ISSUE cycles then accepts
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      checkOutput("hold_valid", 32'(bus.redirect_valid), 32'd1);
      checkOutput("hold_pc",    bus.redirect_pc, 32'h100);
      checkOutput("hold_count", 32'(bus.redirect_count), 32'd2);
      if (i == 5) bus.fetch_ready = 1'b1;
      tick();
    end
    checkOutput("hold_done_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("hold_done_count", 32'(bus.redirect_count), 32'd3);
    tick();
    checkOutput("hold_once_count", 32'(bus.redirect_count), 32'd3);

    // Second mispredict in the last FLUSH cycle restarts the full flush
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h400, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("late_flush1", 32'(bus.flush_if), 32'd1);
    checkOutput("late_valid1", 32'(bus.redirect_valid), 32'd0);
    tick();
    checkOutput("late_flush2", 32'(bus.flush_if), 32'd1);
    checkOutput("late_valid2", 32'(bus.redirect_valid), 32'd0);
    tick();
    checkOutput("late_issue_valid", 32'(bus.redirect_valid), 32'd1);
    checkOutput("late_issue_pc",    bus.redirect_pc, 32'h400);
    tick();
    checkOutput("late_count", 32'(bus.redirect_count), 32'd4);

    // Mispredict during ISSUE with fetch ready: no handshake; jump while busy ignored
    applyStimulus(1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("iss_pc_500", bus.redirect_pc, 32'h500);
    applyStimulus(1'b1, 32'h603, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h700, 1'b1);
    checkOutput("iss_restart_flush", 32'(bus.flush_if), 32'd1);
    checkOutput("iss_restart_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("iss_restart_count", 32'(bus.redirect_count), 32'd4);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("iss_pc_600", bus.redirect_pc, 32'h600);
    tick();
    checkOutput("iss_count", 32'(bus.redirect_count), 32'd5);
    tick();
    checkOutput("iss_jump_ignored", 32'(bus.busy), 32'd0);

    // Reset pulse during ISSUE; mispredict held across deassertion
    applyStimulus(1'b1, 32'h800, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("rstp_issue_valid", 32'(bus.redirect_valid), 32'd1);
    #2;
    rstn_h = 1'b0;
    applyStimulus(1'b1, 32'h900, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rstp_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("rstp_pc",    bus.redirect_pc, 32'h0);
    checkOutput("rstp_stall", 32'(bus.stall_fetch), 32'd0);
    checkOutput("rstp_busy",  32'(bus.busy), 32'd0);
    checkOutput("rstp_count", 32'(bus.redirect_count), 32'd0);
    tick();
    rstn_h = 1'b1;
    tick();
    checkOutput("rstp_first_edge_busy", 32'(bus.busy), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("rstp_second_edge_busy",  32'(bus.busy), 32'd1);
    checkOutput("rstp_second_edge_flush", 32'(bus.flush_if), 32'd1);
    tick();
    tick();
    checkOutput("rstp_issue_pc", bus.redirect_pc, 32'h900);
    tick();
    checkOutput("rstp_after_count", 32'(bus.redirect_count), 32'd1);

    // 300 back-to-back redirects: counter saturates at 255
    exp_count = 1;
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'b1, 32'h1000 + 32'(n * 4), 1'b0, 32'h0, 1'b1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      tick();
      tick();
      tick();
      if (exp_count < 255) exp_count++;
      checkOutput("sat_count", 32'(bus.redirect_count), 32'(exp_count));
    end
    checkOutput("sat_final", 32'(bus.redirect_count), 32'd255);
    checkOutput("sat_busy",  32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
